// File: rtl/csi2tx_sensor_fifo_writer_pkg.sv
// Shared definitions for the CSI-2 TX sensor FIFO writer: FSM encoding and
// FIFO word geometry.
package csi2tx_sensor_fifo_writer_pkg;

  localparam int unsigned BytesPerWord = 4;
  localparam int unsigned FifoDataW    = 32;
  localparam int unsigned ByteIdxW     = $clog2(BytesPerWord);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFrame = 2'd1,
    StLine  = 2'd2,
    StEol   = 2'd3
  } state_e;

endpackage

// File: rtl/csi2tx_sensor_fifo_writer_if.sv
// Sensor byte stream plus FIFO controller write port. The writer is the slave
// of the sensor stream and drives the FIFO write side.
interface csi2tx_sensor_fifo_writer_if;
  import csi2tx_sensor_fifo_writer_pkg::*;

  logic                 pix_vld;
  logic [7:0]           pix_data;
  logic                 pix_last;
  logic                 pix_rdy;
  logic                 almost_full;
  logic                 fifo_full_wr_dm;
  logic                 wr_en;
  logic [FifoDataW-1:0] wr_data;

  modport master (
    output pix_vld, pix_data, pix_last, almost_full, fifo_full_wr_dm,
    input  pix_rdy, wr_en, wr_data
  );

  modport slave (
    input  pix_vld, pix_data, pix_last, almost_full, fifo_full_wr_dm,
    output pix_rdy, wr_en, wr_data
  );

endinterface

// File: rtl/csi2tx_sensor_fifo_writer_byte_packer.sv
// Little-endian byte-to-word packer: collects accepted bytes into lanes and
// flags a complete word on lane 3, on the line's last byte, or on a flush.
module csi2tx_sensor_fifo_writer_byte_packer
  import csi2tx_sensor_fifo_writer_pkg::*;
#(
  parameter logic [7:0] PadByte = 8'h00
) (
  input  logic                 clk_wr,
  input  logic                 rst_wr_n,
  input  logic                 clr,
  input  logic                 byte_vld,
  input  logic [7:0]           byte_data,
  input  logic                 byte_last,
  input  logic                 flush,
  output logic                 word_cmplt,
  output logic [FifoDataW-1:0] word_data
);

  logic [BytesPerWord-1:0][7:0] lane_q, lane_d;
  logic [ByteIdxW-1:0]          idx_q, idx_d;
  logic                         last_eff;

  always_comb begin
    last_eff   = byte_last | flush;
    // A flush with no byte this cycle only emits a word if lanes are occupied.
    word_cmplt = byte_vld ? ((idx_q == ByteIdxW'(BytesPerWord - 1)) || last_eff)
                          : (flush && (idx_q != '0));
    word_data  = '0;
    for (int i = 0; i < BytesPerWord; i++) begin
      if (byte_vld && (idx_q == ByteIdxW'(i))) begin
        word_data[8*i +: 8] = byte_data;
      end else if (ByteIdxW'(i) < idx_q) begin
        word_data[8*i +: 8] = lane_q[i];
      end else begin
        word_data[8*i +: 8] = PadByte;
      end
    end
  end

  always_comb begin
    lane_d = lane_q;
    idx_d  = idx_q;
    if (byte_vld) begin
      lane_d[idx_q] = byte_data;
      idx_d         = word_cmplt ? '0 : idx_q + ByteIdxW'(1);
    end else if (flush) begin
      idx_d = '0;
    end
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      lane_q <= '0;
      idx_q  <= '0;
    end else if (clr) begin
      lane_q <= '0;
      idx_q  <= '0;
    end else begin
      lane_q <= lane_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/csi2tx_sensor_fifo_writer.sv
// CSI-2 TX sensor FIFO writer: frame/line FSM, backpressure, line byte count and
// error flags. CSI2TX_SENSOR_WR_DROP_CNT_EN adds a saturating dropped-word count.
module csi2tx_sensor_fifo_writer
  import csi2tx_sensor_fifo_writer_pkg::*;
#(
  parameter int unsigned WC_W     = 16,
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic                          clk_wr,
  input  logic                          rst_wr_n,
  input  logic                          tinit_start_csi_clk,
  input  logic                          frame_start,
  input  logic                          frame_end,
  csi2tx_sensor_fifo_writer_if.slave    bus,
  output logic                          line_wc_vld,
  output logic [WC_W-1:0]               line_wc,
  output logic                          ovf_err,
  output logic                          trunc_err
`ifdef CSI2TX_SENSOR_WR_DROP_CNT_EN
  ,
  output logic [15:0]                   drop_cnt
`endif
);

  state_e               state_q, state_d;
  logic                 clr;
  logic                 line_busy, pix_rdy, accept, eol_acc, trunc, combo;
  logic                 word_cmplt;
  logic [FifoDataW-1:0] word_data;
  logic                 wr_vld_q;
  logic [FifoDataW-1:0] wr_data_q;
  logic [WC_W-1:0]      cnt_q, cnt_d, cnt_inc, line_wc_q, line_wc_d;
  logic                 line_wc_vld_q, ovf_q, trunc_q;
  logic                 err_clr, ovf_set;

  assign clr = ~tinit_start_csi_clk;

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state_q <= StIdle;
    end else if (clr) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (frame_start) state_d = StFrame;
      StFrame, StLine: begin
        if (eol_acc) begin
          state_d = frame_end ? StIdle : StEol;
        end else if (frame_end) begin
          state_d = StIdle;
        end else if (accept) begin
          state_d = StLine;
        end
      end
      StEol:   state_d = frame_end ? StIdle : StFrame;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    line_busy = (state_q == StFrame) || (state_q == StLine);
    pix_rdy   = line_busy && !bus.almost_full && !bus.fifo_full_wr_dm;
    accept    = bus.pix_vld && pix_rdy;
    eol_acc   = accept && bus.pix_last;
    // Mid-line means at least one byte of the current line has been taken.
    trunc     = line_busy && frame_end && !eol_acc && ((state_q == StLine) || accept);
    combo     = eol_acc && frame_end;
  end

  csi2tx_sensor_fifo_writer_byte_packer #(
    .PadByte (PAD_BYTE)
  ) u_packer (
    .clk_wr     (clk_wr),
    .rst_wr_n   (rst_wr_n),
    .clr        (clr),
    .byte_vld   (accept),
    .byte_data  (bus.pix_data),
    .byte_last  (bus.pix_last),
    .flush      (trunc),
    .word_cmplt (word_cmplt),
    .word_data  (word_data)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + WC_W'(1);
  assign err_clr = (state_q == StIdle) && frame_start;
  assign ovf_set = wr_vld_q && bus.fifo_full_wr_dm;

  always_comb begin
    cnt_d = cnt_q;
    if ((state_d == StFrame) && (state_q != StFrame)) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = cnt_inc;
    end
    line_wc_d = line_wc_q;
    if (state_q == StEol) begin
      line_wc_d = cnt_q;
    end else if (combo) begin
      line_wc_d = cnt_inc;
    end
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      cnt_q         <= '0;
      line_wc_q     <= '0;
      line_wc_vld_q <= 1'b0;
      wr_vld_q      <= 1'b0;
      wr_data_q     <= '0;
      ovf_q         <= 1'b0;
      trunc_q       <= 1'b0;
    end else if (clr) begin
      cnt_q         <= '0;
      line_wc_q     <= '0;
      line_wc_vld_q <= 1'b0;
      wr_vld_q      <= 1'b0;
      wr_data_q     <= '0;
      ovf_q         <= 1'b0;
      trunc_q       <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      line_wc_q     <= line_wc_d;
      line_wc_vld_q <= (state_q == StEol) || combo;
      wr_vld_q      <= word_cmplt;
      if (word_cmplt) wr_data_q <= word_data;
      ovf_q         <= (ovf_q & ~err_clr) | ovf_set;
      trunc_q       <= (trunc_q & ~err_clr) | trunc;
    end
  end

`ifdef CSI2TX_SENSOR_WR_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = err_clr ? '0 : drop_cnt_q;
    if (ovf_set && (drop_cnt_d != '1)) drop_cnt_d = drop_cnt_d + 16'd1;
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      drop_cnt_q <= '0;
    end else if (clr) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  // The full check happens on the write cycle itself, so the strobe is gated here.
  assign bus.wr_en   = wr_vld_q & ~bus.fifo_full_wr_dm;
  assign bus.wr_data = wr_data_q;
  assign bus.pix_rdy = pix_rdy;
  assign line_wc_vld = line_wc_vld_q;
  assign line_wc     = line_wc_q;
  assign ovf_err     = ovf_q;
  assign trunc_err   = trunc_q;

endmodule

// File: tb/tb_csi2tx_sensor_fifo_writer.sv
// Directed and randomized bench for csi2tx_sensor_fifo_writer, checked against
// a byte-list packing model kept in the bench.
module tb_csi2tx_sensor_fifo_writer;

  logic        clk_wr = 1'b0;
  logic        rst_wr_n = 1'b0;
  logic        tinit_start_csi_clk = 1'b1;
  logic        frame_start = 1'b0;
  logic        frame_end = 1'b0;
  logic        line_wc_vld;
  logic [15:0] line_wc;
  logic        ovf_err;
  logic        trunc_err;
`ifdef CSI2TX_SENSOR_WR_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  csi2tx_sensor_fifo_writer_if bus ();

  csi2tx_sensor_fifo_writer #(
    .WC_W     (16),
    .PAD_BYTE (8'h00)
  ) dut (
    .clk_wr              (clk_wr),
    .rst_wr_n            (rst_wr_n),
    .tinit_start_csi_clk (tinit_start_csi_clk),
    .frame_start         (frame_start),
    .frame_end           (frame_end),
    .bus                 (bus),
    .line_wc_vld         (line_wc_vld),
    .line_wc             (line_wc),
    .ovf_err             (ovf_err),
    .trunc_err           (trunc_err)
`ifdef CSI2TX_SENSOR_WR_DROP_CNT_EN
    ,
    .drop_cnt            (drop_cnt)
`endif
  );

  always #5 clk_wr = ~clk_wr;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0]  line_q[$];
  logic [31:0] exp_w[$];
  logic [31:0] got_w[$];
  int          got_w_cyc[$];
  logic [15:0] got_wc[$];
  int          got_wc_cyc[$];

  always @(posedge clk_wr) cyc <= cyc + 1;

  always @(negedge clk_wr) begin
    if (bus.wr_en) begin
      got_w.push_back(bus.wr_data);
      got_w_cyc.push_back(cyc);
    end
    if (line_wc_vld) begin
      got_wc.push_back(line_wc);
      got_wc_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    got_w.delete(); got_w_cyc.delete(); got_wc.delete(); got_wc_cyc.delete(); exp_w.delete();
  endtask

  task automatic load_seq(input logic [7:0] first, input int n);
    line_q.delete();
    for (int i = 0; i < n; i++) line_q.push_back(first + 8'(i));
  endtask

  task automatic load_rand(input int n);
    line_q.delete();
    for (int i = 0; i < n; i++) line_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Model: first n bytes of line_q, little-endian, zero-padded last word.
  task automatic expect_words(input int n);
    for (int w = 0; w < (n + 3) / 4; w++) begin
      logic [31:0] word = 32'h0;
      for (int b = 0; b < 4; b++) begin
        if (4 * w + b < n) word = word | (32'(line_q[4 * w + b]) << (8 * b));
      end
      exp_w.push_back(word);
    end
  endtask

  task automatic cmp_words(input string tag);
    chk({tag, "_nwords"}, 64'(got_w.size()), 64'(exp_w.size()));
    for (int k = 0; k < exp_w.size() && k < got_w.size(); k++) begin
      chk({tag, "_word"}, 64'(got_w[k]), 64'(exp_w[k]));
    end
    got_w.delete(); got_w_cyc.delete(); exp_w.delete();
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    @(posedge clk_wr); #1;
    frame_start = 1'b0;
  endtask

  task automatic pulse_fe();
    frame_end = 1'b1;
    @(posedge clk_wr); #1;
    frame_end = 1'b0;
  endtask

  // Entered and left at posedge+1; returns right after the last byte's accept edge.
  task automatic send_line(input int n, input bit mark_last, input bit rnd, input bit fe_on_last,
                           input int af_at, input int af_len);
    int i = 0;
    int guard = 0;
    int af_cnt = 0;
    bit gap, af, forced, acc;
    while (i < n && guard < 2000) begin
      gap    = rnd && ($urandom_range(0, 3) == 0);
      forced = (i == af_at) && (af_cnt < af_len);
      if (forced) af_cnt++;
      af = forced || (rnd && ($urandom_range(0, 4) == 0));
      bus.pix_vld     = !gap;
      bus.pix_data    = line_q[i];
      bus.pix_last    = mark_last && (i == n - 1);
      bus.almost_full = af;
      frame_end       = fe_on_last && (i == n - 1) && !gap;
      @(negedge clk_wr);
      acc = bus.pix_vld && bus.pix_rdy;
      if (forced) chk("stall_rdy", 64'(bus.pix_rdy), 64'(0));
      @(posedge clk_wr); #1;
      if (acc) i++;
      guard++;
    end
    bus.pix_vld = 1'b0; bus.pix_last = 1'b0; bus.almost_full = 1'b0; frame_end = 1'b0;
    chk("send_done", 64'(i), 64'(n));
  endtask

  task automatic wait_wc(input int prev);
    int k = 0;
    while (got_wc.size() <= prev && k < 20) begin
      @(posedge clk_wr); #1;
      k++;
    end
    chk("wc_pulse", 64'(got_wc.size()), 64'(prev + 1));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rdy"}, 64'(bus.pix_rdy), 64'(0));
    chk({tag, "_wr_en"}, 64'(bus.wr_en), 64'(0));
    chk({tag, "_wr_data"}, 64'(bus.wr_data), 64'(0));
    chk({tag, "_wc_vld"}, 64'(line_wc_vld), 64'(0));
    chk({tag, "_wc"}, 64'(line_wc), 64'(0));
    chk({tag, "_ovf"}, 64'(ovf_err), 64'(0));
    chk({tag, "_trunc"}, 64'(trunc_err), 64'(0));
`ifdef CSI2TX_SENSOR_WR_DROP_CNT_EN
    chk({tag, "_drop"}, 64'(drop_cnt), 64'(0));
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.pix_vld = 1'b0; bus.pix_data = 8'h00; bus.pix_last = 1'b0;
    bus.almost_full = 1'b0; bus.fifo_full_wr_dm = 1'b0;
    repeat (3) @(posedge clk_wr);
    @(negedge clk_wr);
    rst_wr_n = 1'b1;
    check_zero("reset");
    @(posedge clk_wr); #1;

    // 8-byte line, then 6-byte line, no backpressure
    clear_q();
    pulse_fs();
    load_seq(8'h01, 8);
    send_line(8, 1, 0, 0, -1, 0);
    expect_words(8);
    wait_wc(0);
    chk("l8_wc", 64'(got_wc[0]), 64'(8));
    chk("l8_vld_timing", 64'(got_wc_cyc[0]), 64'(got_w_cyc[1] + 1));
    chk("l8_w0", 64'(got_w[0]), 64'(32'h04030201));
    cmp_words("l8");
    clear_q();
    load_seq(8'hA0, 6);
    send_line(6, 1, 0, 0, -1, 0);
    expect_words(6);
    wait_wc(0);
    chk("l6_wc", 64'(got_wc[0]), 64'(6));
    chk("l6_w1", 64'(got_w[1]), 64'(32'h0000A5A4));
    cmp_words("l6");

    // almost_full stall of 5 cycles after the third byte
    clear_q();
    load_seq(8'h01, 8);
    send_line(8, 1, 0, 0, 3, 5);
    expect_words(8);
    wait_wc(0);
    chk("stall_wc", 64'(got_wc[0]), 64'(8));
    cmp_words("stall");
    pulse_fe();

    // overflow on the write cycle of a 4-byte line
    clear_q();
    pulse_fs();
    load_seq(8'h40, 4);
    send_line(4, 1, 0, 0, -1, 0);
    bus.fifo_full_wr_dm = 1'b1;
    @(negedge clk_wr);
    chk("ovf_wr_en", 64'(bus.wr_en), 64'(0));
    @(posedge clk_wr); #1;
    bus.fifo_full_wr_dm = 1'b0;
    chk("ovf_err", 64'(ovf_err), 64'(1));
`ifdef CSI2TX_SENSOR_WR_DROP_CNT_EN
    chk("ovf_drop", 64'(drop_cnt), 64'(1));
`endif
    wait_wc(0);
    chk("ovf_wc", 64'(got_wc[0]), 64'(4));
    chk("ovf_nwords", 64'(got_w.size()), 64'(0));
    pulse_fe();
    chk("ovf_hold", 64'(ovf_err), 64'(1));
    pulse_fs();
    chk("ovf_clr", 64'(ovf_err), 64'(0));
`ifdef CSI2TX_SENSOR_WR_DROP_CNT_EN
    chk("drop_clr", 64'(drop_cnt), 64'(0));
`endif

    // frame_end after three bytes of a line
    clear_q();
    line_q.delete();
    line_q.push_back(8'h11); line_q.push_back(8'h22); line_q.push_back(8'h33);
    send_line(3, 0, 0, 0, -1, 0);
    pulse_fe();
    repeat (3) begin @(posedge clk_wr); #1; end
    expect_words(3);
    chk("trunc_word", 64'(got_w[0]), 64'(32'h00332211));
    cmp_words("trunc");
    chk("trunc_err", 64'(trunc_err), 64'(1));
    chk("trunc_idle", 64'(bus.pix_rdy), 64'(0));
    chk("trunc_no_wc", 64'(got_wc.size()), 64'(0));

    // frame_end together with the last byte
    clear_q();
    pulse_fs();
    chk("trunc_clr", 64'(trunc_err), 64'(0));
    load_seq(8'h5A, 2);
    send_line(2, 1, 0, 1, -1, 0);
    wait_wc(0);
    repeat (2) begin @(posedge clk_wr); #1; end
    expect_words(2);
    cmp_words("combo");
    chk("combo_wc", 64'(got_wc[0]), 64'(2));
    chk("combo_trunc", 64'(trunc_err), 64'(0));
    chk("combo_idle", 64'(bus.pix_rdy), 64'(0));

    // synchronous clear mid-line, then a fresh line packs from lane 0
    clear_q();
    pulse_fs();
    load_seq(8'h71, 2);
    send_line(2, 0, 0, 0, -1, 0);
    tinit_start_csi_clk = 1'b0;
    @(posedge clk_wr); #1;
    tinit_start_csi_clk = 1'b1;
    check_zero("tinit");
    clear_q();
    pulse_fs();
    load_seq(8'hC1, 4);
    send_line(4, 1, 0, 0, -1, 0);
    expect_words(4);
    wait_wc(0);
    chk("fresh_word", 64'(got_w[0]), 64'(32'hC4C3C2C1));
    cmp_words("fresh");
    chk("fresh_wc", 64'(got_wc[0]), 64'(4));

    // random lines with random gaps and almost_full
    for (int r = 0; r < 8; r++) begin
      clear_q();
      n = $urandom_range(1, 20);
      load_rand(n);
      send_line(n, 1, 1, 0, -1, 0);
      expect_words(n);
      wait_wc(0);
      chk("rand_wc", 64'(got_wc[0]), 64'(n));
      cmp_words("rand");
    end
    pulse_fe();
    repeat (2) begin @(posedge clk_wr); #1; end
    chk("end_idle", 64'(bus.pix_rdy), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/csi2tx_sensor_fifo_writer.md
Name: csi2tx_sensor_fifo_writer

Overview:
Write-side producer for the CSI-2 TX sensor FIFO, running in the csi clock domain.
- Accepts a byte-wide sensor pixel stream with a valid/ready handshake.
- Packs bytes little-endian into 32-bit words and drives the FIFO controller's write enable and data.
- Applies backpressure from the controller's almost_full and full flags.
- At each line end, reports the line byte count, which the packet-header builder uses as the word count.

Parameters:
WC_W  16  width of line byte counter / reported word count
PAD_BYTE  8'h00  fill value for unused byte lanes of a partial last word

Ports:
clk_wr  in  1  csi-domain clock (FIFO write clock)
rst_wr_n  in  1  asynchronous active-low reset
tinit_start_csi_clk  in  1  0 = synchronous clear of all state (same as reset)
frame_start  in  1  single-cycle pulse, start of frame
frame_end  in  1  single-cycle pulse, end of frame
pix_vld  in  1  sensor byte valid
pix_data  in  8  sensor byte
pix_last  in  1  qualifies pix_data as last byte of the line
pix_rdy  out  1  writer can accept a byte this cycle
almost_full  in  1  from FIFO controller
fifo_full_wr_dm  in  1  from FIFO controller
wr_en  out  1  FIFO write strobe, one word
wr_data  out  32  FIFO write word, byte0 in [7:0]
line_wc_vld  out  1  one-cycle pulse, line_wc valid
line_wc  out  WC_W  bytes in the line just completed
ovf_err  out  1  sticky: a word was dropped because the FIFO was full
trunc_err  out  1  sticky: frame_end arrived mid-line

Behaviour:
- Reset or tinit_start_csi_clk=0 clears everything:
  - state=IDLE
  - all outputs 0, except wr_data=0 and line_wc=0
- A byte is accepted when pix_vld && pix_rdy.
  - pix_rdy = (state==LINE || state==FRAME) && !almost_full && !fifo_full_wr_dm
  - pix_rdy is combinational from registered state and the two flags.
- FSM:
  - IDLE: frame_start -> FRAME; bytes are not accepted in IDLE.
  - FRAME: first accepted byte -> LINE; frame_end -> IDLE.
  - LINE: accepted byte with pix_last -> EOL; frame_end -> IDLE, with a partial word flushed and trunc_err set.
  - EOL: one cycle; pix_rdy=0; line_wc_vld=1 -> FRAME.
- frame_start is ignored outside IDLE.
- Packing:
  - 2-bit byte_idx; an accepted byte is stored in lane byte_idx.
  - Lane 3 accepted or pix_last accepted -> word complete.
  - Unfilled lanes take PAD_BYTE; byte_idx returns to 0.
- Write latency: wr_en and wr_data are registered and assert the cycle after the completing byte is accepted. wr_en is a single-cycle pulse per word.
- Overflow: if fifo_full_wr_dm=1 in the cycle the word would be written:
  - wr_en is suppressed and the word is dropped.
  - ovf_err is set.
- Line counter:
  - Increments per accepted byte and saturates at 2^WC_W-1.
  - Copied to line_wc in EOL, coincident with line_wc_vld; line_wc holds until the next EOL.
  - Counter clears on entry to FRAME.
- ovf_err and trunc_err clear only on frame_start accepted in IDLE, or on reset.
- frame_end and pix_last accepted in the same cycle: the last byte completes normally (word written, no trunc_err), EOL is skipped, line_wc_vld still pulses in the next cycle, and state goes to IDLE.

Optional Feature:
CSI2TX_SENSOR_WR_DROP_CNT_EN
- Defined: adds output drop_cnt[15:0], a saturating count of dropped words. It clears with ovf_err.
- Undefined: no port; ovf_err only.

Decomposition:
- Shared package (csi2tx_defines): FSM state encodings (IDLE, FRAME, LINE, EOL), BYTES_PER_WORD=4, FIFO data width 32.
- One sub-module is natural: csi2tx_byte_packer. It holds the lane registers, byte_idx, padding and the word-complete flag. The top level holds the FSM, counters, error flags and handshake.

Test Plan:
- Line of 8 bytes 0x01..0x08, no backpressure -> wr_en pulses twice, with 0x04030201 then 0x08070605; line_wc=8 with line_wc_vld one cycle after the second wr_en.
- Line of 6 bytes 0xA0..0xA5 -> second word 0x0000A5A4; line_wc=6.
- almost_full held high for 5 cycles mid-line -> pix_rdy=0 for those cycles, no bytes lost; data is identical to the unstalled run.
- fifo_full_wr_dm=1 forced on the word-write cycle of a 4-byte line -> no wr_en, ovf_err=1; with CSI2TX_SENSOR_WR_DROP_CNT_EN, drop_cnt=1. Both clear on the next frame_start.
- frame_end after 3 bytes 0x11,0x22,0x33 -> wr_data=0x00332211 written, trunc_err=1, state IDLE, no line_wc_vld.
- tinit_start_csi_clk driven 0 mid-line -> all outputs 0 the next cycle; a fresh frame afterwards packs from lane 0.
